display_mmio: RTL
=================

# display_mmio

Memory-mapped 4-digit multiplexed seven-segment display peripheral. Sits on the CPU data bus as a responder to `DataAdr`/`WriteData`/`MemWrite` stores and loads. Holds a 16-bit hex value plus control, and time-multiplexes it onto a common-anode display through the team's existing `seven_segments` hex decoder. Replaces ad-hoc direct wiring of CPU bus bits to the display.

## Interface
- `BASE_ADDR`, default 32'h0000_0400: word-aligned base of the 3-register window.
- `NUM_DIGITS`, default 4: number of display digits. Legal range 1..4.
- `SCAN_DIV`, default 50000: clock cycles each digit stays lit. Must be ≥ 2.
- `BLINK_BITS`, default 8: width of the full-scan counter. Its MSB is the blink phase.

Ports:
- `clk` in 1: single clock. All state changes on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `MemWrite` in 1: store strobe from the CPU.
- `DataAdr` in 32: byte address.
- `WriteData` in 32: store data.
- `ReadData` out 32: load data. Combinational from address and registers.
- `an` out NUM_DIGITS: digit anode enables, active-low.
- `segments` out 7: {g,f,e,d,c,b,a}, active-low.

## Operation
- Register map, at offset from BASE_ADDR:
  - 0x0 DATA, R/W: bits [15:0], 4 bits per digit, digit 0 = [3:0]. Upper bits read 0.
  - 0x4 CTRL, R/W: [3:0] digit enable mask, [8] blank, [9] blink. Other bits read 0.
  - 0x8 STATUS, RO: [1:0] current digit index, [31:16] accepted-DATA-write count (wraps at 16'hFFFF→0).
- Hit condition: `DataAdr[31:4] == BASE_ADDR[31:4]` and `DataAdr[1:0] == 0` and offset ∈ {0x0, 0x4, 0x8}.
- Write accepted when `MemWrite` && hit && offset ≠ 0x8. Writes to STATUS, misaligned addresses and misses are ignored.
- ReadData returns the addressed register on a hit, else 32'h0. MemWrite does not affect the read path.
- Scan engine:
  - Prescaler counts 0..SCAN_DIV-1. At terminal count it returns to 0 and the digit index advances, wrapping NUM_DIGITS-1→0.
  - Each index wrap increments a BLINK_BITS-bit full-scan counter. Blink phase = its MSB.
- Output per digit slot `i`:
  - `an[i]=0` only if CTRL[8]=0 and mask[i]=1 and not (CTRL[9]=1 and phase=1). Otherwise all anodes are 1.
  - `segments` = `seven_segments(DATA[4i+3:4i])` when the slot is lit, else 7'h7F.
  - Slots with mask bit 0 still consume their full time slot.

## Timing
- Reset (asserted low, asynchronous):
  - DATA=0, CTRL=32'h0000_000F, prescaler=0, index=0, scan counter=0, write count=0.
  - `an` all 1 and `segments`=7'h7F for one cycle. Outputs are registered.
- Release: digit 0 is lit from the first rising edge after reset deasserts.
- Write latency: a store at edge N updates the register at edge N. A read in cycle N+1 returns the new value.
- Display latency: `an`/`segments` are registered. A register or index change at edge N is visible after edge N+1.
- DATA write in the same cycle as a digit advance: the new slot shows the new value, one cycle late per the rule above.
- Write count increments on the same edge as the accepted DATA write.
- Reset mid-scan aborts the slot immediately. There is no partial state retention.

## Structure
- Package `display_pkg`:
  - register offset constants (DATA_OFF, CTRL_OFF, STATUS_OFF)
  - CTRL bit positions
  - CTRL reset value
  - SEG_OFF = 7'h7F
- Sub-module: reuse the existing `seven_segments` (4-bit data → 7-bit segments). Instantiate it once on the muxed nibble.
- Single module otherwise, comprising:
  - bus decode
  - register file
  - scan counters
  - output register

## Test plan
Parameters for all cases: SCAN_DIV=4, NUM_DIGITS=4, BLINK_BITS=2.
- **Reset/idle:** release reset → `an`=4'b1110 after first edge. Digit 0 shows encoding of 0. Index rotates every 4 cycles 0→1→2→3→0. CTRL reads 32'hF.
- **Store/load:** write 32'hABCD_1234 to DATA.
  - DATA reads 32'h0000_1234.
  - STATUS[31:16]=1.
  - Each slot shows 4,3,2,1 for digits 0..3.
- **Ignored accesses:**
  - Write to BASE+0x8, BASE+0x2 and BASE+0x10 → no register change, write count unchanged.
  - Read BASE+0x10 → 0.
- **Mask/blank:**
  - CTRL=32'h5 → anodes 1 and 3 never go low; slot timing unchanged.
  - CTRL=32'h10F → `an` all 1, `segments`=7'h7F.
- **Blink:** CTRL=32'h20F → display lit for 2 full scans (32 cycles), dark for 2, and repeats.
- **Async reset mid-slot:** assert `rst` low between edges during digit 2 → DATA=0 and outputs off immediately. After release, scan restarts at digit 0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants and types for the memory-mapped seven-segment display peripheral.
// Register offsets, CTRL field layout and reset values live here.
package display_pkg;

  localparam logic [3:0] DATA_OFF   = 4'h0;
  localparam logic [3:0] CTRL_OFF   = 4'h4;
  localparam logic [3:0] STATUS_OFF = 4'h8;

  localparam int CTRL_MASK_LSB  = 0;
  localparam int CTRL_BLANK_BIT = 8;
  localparam int CTRL_BLINK_BIT = 9;

  localparam logic [31:0] CTRL_RST = 32'h0000_000F;
  localparam logic [6:0]  SEG_OFF  = 7'h7F;

  typedef enum logic [1:0] {
    REG_DATA,
    REG_CTRL,
    REG_STATUS,
    REG_NONE
  } reg_sel_e;

  typedef struct packed {
    logic       blink;
    logic       blank;
    logic [3:0] mask;
  } ctrl_t;

  // Maps a word-aligned offset inside the 16-byte window to a register.
  function automatic reg_sel_e decode_offset(input logic [3:0] off);
    case (off)
      DATA_OFF:   return REG_DATA;
      CTRL_OFF:   return REG_CTRL;
      STATUS_OFF: return REG_STATUS;
      default:    return REG_NONE;
    endcase
  endfunction

  function automatic ctrl_t ctrl_from_word(input logic [31:0] w);
    ctrl_t c;
    c.blink = w[CTRL_BLINK_BIT];
    c.blank = w[CTRL_BLANK_BIT];
    c.mask  = w[CTRL_MASK_LSB +: 4];
    return c;
  endfunction

  function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
    logic [31:0] w;
    w = 32'h0;
    w[CTRL_BLINK_BIT]     = c.blink;
    w[CTRL_BLANK_BIT]     = c.blank;
    w[CTRL_MASK_LSB +: 4] = c.mask;
    return w;
  endfunction

endpackage

// File: rtl/seven_segments.sv
// Hex nibble to common-anode seven-segment pattern, {g,f,e,d,c,b,a}, active-low.
module seven_segments (
  input  logic [3:0] data,
  output logic [6:0] segments
);

  always_comb begin
    segments = 7'h7F;
    case (data)
      4'h0: segments = 7'b100_0000;
      4'h1: segments = 7'b111_1001;
      4'h2: segments = 7'b010_0100;
      4'h3: segments = 7'b011_0000;
      4'h4: segments = 7'b001_1001;
      4'h5: segments = 7'b001_0010;
      4'h6: segments = 7'b000_0010;
      4'h7: segments = 7'b111_1000;
      4'h8: segments = 7'b000_0000;
      4'h9: segments = 7'b001_0000;
      4'hA: segments = 7'b000_1000;
      4'hB: segments = 7'b000_0011;
      4'hC: segments = 7'b100_0110;
      4'hD: segments = 7'b010_0001;
      4'hE: segments = 7'b000_0110;
      4'hF: segments = 7'b000_1110;
      default: segments = 7'h7F;
    endcase
  end

endmodule

// File: rtl/display_mmio.sv
// Bus-attached 4-digit multiplexed seven-segment display: DATA/CTRL/STATUS registers,
// a prescaled digit scan with blink phase, and registered anode/segment drive.
module display_mmio
  import display_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
  parameter int          NUM_DIGITS = 4,
  parameter int          SCAN_DIV   = 50000,
  parameter int          BLINK_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemWrite,
  input  logic [31:0]           DataAdr,
  input  logic [31:0]           WriteData,
  output logic [31:0]           ReadData,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            segments
);

  localparam int              PW         = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [1:0]      IDX_LAST   = 2'(NUM_DIGITS - 1);

  reg_sel_e sel;
  logic     wr_data, wr_ctrl;

  logic [15:0]           data_q, data_d;
  ctrl_t                 ctrl_q, ctrl_d;
  logic [15:0]           wcnt_q, wcnt_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [1:0]            idx_q, idx_d;
  logic [BLINK_BITS-1:0] scan_q, scan_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;

  logic       lit;
  logic [3:0] nibble;
  logic [6:0] seg_dec;

  logic unused_wdata;
  assign unused_wdata = ^WriteData[31:16];

  // Only word-aligned accesses to the three defined slots of our window hit.
  always_comb begin
    sel = REG_NONE;
    if (DataAdr[31:4] == BASE_ADDR[31:4] && DataAdr[1:0] == 2'b00) begin
      sel = decode_offset(DataAdr[3:0]);
    end
  end

  assign wr_data = MemWrite && (sel == REG_DATA);
  assign wr_ctrl = MemWrite && (sel == REG_CTRL);

  always_comb begin
    ReadData = 32'h0;
    case (sel)
      REG_DATA:   ReadData = {16'h0, data_q};
      REG_CTRL:   ReadData = ctrl_to_word(ctrl_q);
      REG_STATUS: ReadData = {wcnt_q, 14'h0, idx_q};
      default:    ReadData = 32'h0;
    endcase
  end

  always_comb begin
    data_d = data_q;
    ctrl_d = ctrl_q;
    wcnt_d = wcnt_q;
    if (wr_data) begin
      data_d = WriteData[15:0];
      wcnt_d = wcnt_q + 16'd1;
    end
    if (wr_ctrl) begin
      ctrl_d = ctrl_from_word(WriteData);
    end
  end

  // Each digit holds for SCAN_DIV cycles; a full pass over the digits bumps the blink counter.
  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    scan_d  = scan_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d  = 2'd0;
        scan_d = scan_q + BLINK_BITS'(1);
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end
  end

  always_comb begin
    nibble = 4'h0;
    case (idx_q)
      2'd0:    nibble = data_q[3:0];
      2'd1:    nibble = data_q[7:4];
      2'd2:    nibble = data_q[11:8];
      default: nibble = data_q[15:12];
    endcase
  end

  seven_segments u_dec (
    .data     (nibble),
    .segments (seg_dec)
  );

  assign lit = !ctrl_q.blank && ctrl_q.mask[idx_q] &&
               !(ctrl_q.blink && scan_q[BLINK_BITS-1]);

  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (lit && idx_q == 2'(i)) begin
        an_d[i] = 1'b0;
      end
    end
    if (lit) begin
      seg_d = seg_dec;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= 16'h0;
      ctrl_q  <= ctrl_from_word(CTRL_RST);
      wcnt_q  <= 16'h0;
      presc_q <= '0;
      idx_q   <= 2'd0;
      scan_q  <= '0;
      an_q    <= '1;
      seg_q   <= SEG_OFF;
    end else begin
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      wcnt_q  <= wcnt_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      scan_q  <= scan_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an       = an_q;
  assign segments = seg_q;

endmodule
